// File: rtl/c_pkg.sv
// Shared definitions for the compressed-aware fetch buffer: fetch FSM states,
// the canonical NOP and the 16/32-bit length decode.
package c_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } fetch_state_e;

  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/c_hw_fifo.sv
// Halfword circular queue with up to two pushes and two pops per cycle,
// two-entry peek at the head and a flush that empties it in one cycle.
module c_hw_fifo
  import c_pkg::*;
#(
  parameter int DEPTH_HW = 8,
  localparam int PW = $clog2(DEPTH_HW),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  logic [15:0]   push_hw0,
  input  logic [15:0]   push_hw1,
  input  logic [1:0]    pop_cnt,
  output logic [15:0]   h0,
  output logic [15:0]   h1,
  output logic [CW-1:0] count
);

  logic [15:0]   mem_r [DEPTH_HW];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr1_s;
  logic [PW-1:0] wr_ptr1_s;
  logic [CW-1:0] count_r;

  // Neighbouring slots; pointer width makes the add wrap at DEPTH_HW.
  always_comb begin
    rd_ptr1_s = rd_ptr_r + PW'(1);
    wr_ptr1_s = wr_ptr_r + PW'(1);
  end

  // Storage write: first halfword at wr_ptr, second in the following slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_HW; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (!flush) begin
      if (push_cnt != 2'd0) begin
        mem_r[wr_ptr_r] <= push_hw0;
      end
      if (push_cnt == 2'd2) begin
        mem_r[wr_ptr1_s] <= push_hw1;
      end
    end
  end

  // Pointer and occupancy update; flush wins over any push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PW'(push_cnt);
      rd_ptr_r <= rd_ptr_r + PW'(pop_cnt);
      count_r  <= count_r + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  assign h0    = mem_r[rd_ptr_r];
  assign h1    = mem_r[rd_ptr1_s];
  assign count = count_r;

endmodule

// File: rtl/c_fetch_buffer.sv
// Instruction fetch buffer: word-aligned fetches in, one whole 16- or 32-bit
// instruction per handshake out, with redirect flush and in-flight kill.
module c_fetch_buffer
  import c_pkg::*;
#(
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_for_branch,
  input  logic [31:0] branch_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        is_comp_o
);

  localparam int CW = $clog2(DEPTH_HW) + 1;
  localparam logic [CW:0]   REQ_LIMIT = (CW + 1)'(DEPTH_HW - 2);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] TWO_C     = CW'(2);

  fetch_state_e  state_r;
  fetch_state_e  state_nxt_s;
  logic [31:0]   fpc_r;
  logic [31:0]   pc_r;
  logic          drop_r;
  logic          fetch_en_r;

  logic [31:0]   target_s;
  logic [CW-1:0] count_s;
  logic [15:0]   h0_s;
  logic [15:0]   h1_s;
  logic          head_comp_s;
  logic          valid_s;
  logic          fire_s;
  logic          req_s;
  logic          idle_room_ok_s;
  logic          wait_room_ok_s;
  logic [1:0]    push_cnt_s;
  logic [1:0]    pop_cnt_s;
  logic [15:0]   push_hw0_s;
  logic [15:0]   push_hw1_s;
  logic [31:0]   inst_s;

  c_hw_fifo #(
    .DEPTH_HW (DEPTH_HW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (sel_for_branch),
    .push_cnt (push_cnt_s),
    .push_hw0 (push_hw0_s),
    .push_hw1 (push_hw1_s),
    .pop_cnt  (pop_cnt_s),
    .h0       (h0_s),
    .h1       (h1_s),
    .count    (count_s)
  );

  assign target_s = branch_pc_i & 32'hFFFF_FFFE;

  // Response push: the first word after a redirect to an odd halfword keeps only its upper half.
  always_comb begin
    push_cnt_s = 2'd0;
    push_hw0_s = mem_rdata_i[15:0];
    push_hw1_s = mem_rdata_i[31:16];
    if (!sel_for_branch && (state_r == WAIT) && mem_rvalid_i) begin
      if (drop_r) begin
        push_cnt_s = 2'd1;
        push_hw0_s = mem_rdata_i[31:16];
      end else begin
        push_cnt_s = 2'd2;
      end
    end else begin
      push_cnt_s = 2'd0;
    end
  end

  // Head decode and handshake pop.
  always_comb begin
    head_comp_s = is_compressed(h0_s);
    inst_s      = 32'h0000_0000;
    if (head_comp_s) begin
      valid_s = (count_s >= ONE_C);
    end else begin
      valid_s = (count_s >= TWO_C);
    end
    if (valid_s) begin
      inst_s = head_comp_s ? {16'h0000, h0_s} : {h1_s, h0_s};
    end else begin
      inst_s = 32'h0000_0000;
    end
    fire_s = valid_s & inst_ready_i & ~sel_for_branch;
    if (fire_s) begin
      pop_cnt_s = head_comp_s ? 2'd1 : 2'd2;
    end else begin
      pop_cnt_s = 2'd0;
    end
  end

  // Room checks: a new word needs two free slots beyond anything already in flight.
  always_comb begin
    idle_room_ok_s = ({1'b0, count_s} <= REQ_LIMIT);
    wait_room_ok_s = (({1'b0, count_s} + (CW + 1)'(push_cnt_s)) <= REQ_LIMIT);
  end

  // Fetch FSM next state and request.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!sel_for_branch && fetch_en_r && idle_room_ok_s) begin
          req_s       = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (sel_for_branch) begin
          state_nxt_s = mem_rvalid_i ? IDLE : WAIT_KILL;
        end else if (mem_rvalid_i) begin
          if (wait_room_ok_s) begin
            req_s       = 1'b1;
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      WAIT_KILL: begin
        if (mem_rvalid_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_KILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, fetch/issue PCs and drop flag; fetch_en_r keeps mem_req_o low while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      fpc_r      <= {RESET_PC[31:2], 2'b00};
      pc_r       <= RESET_PC;
      drop_r     <= RESET_PC[1];
      fetch_en_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_en_r <= 1'b1;
      if (sel_for_branch) begin
        fpc_r <= target_s & 32'hFFFF_FFFC;
      end else if (req_s) begin
        fpc_r <= fpc_r + 32'd4;
      end
      if (sel_for_branch) begin
        drop_r <= target_s[1];
      end else if (push_cnt_s != 2'd0) begin
        drop_r <= 1'b0;
      end
      if (sel_for_branch) begin
        pc_r <= target_s;
      end else if (fire_s) begin
        pc_r <= pc_r + (head_comp_s ? 32'd2 : 32'd4);
      end
    end
  end

  assign mem_req_o    = req_s;
  assign mem_addr_o   = fpc_r;
  assign inst_valid_o = valid_s;
  assign inst_o       = inst_s;
  assign pc_o         = pc_r;
  assign is_comp_o    = valid_s & head_comp_s;

endmodule

// File: tb/tb_c_fetch_buffer.sv
// Scoreboard bench for c_fetch_buffer: a behavioural memory answers requests
// after a programmable latency; retired instructions are compared to expectations.
module tb_c_fetch_buffer;

  localparam int          DEPTH_HW = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    int          cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_for_branch;
  logic [31:0] branch_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        is_comp_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_words [logic [31:0]];
  rec_t        exp_q[$];
  rec_t        obs_q[$];
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  int          cyc;
  int          first_valid_cyc;
  int          resp_lat;
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_wait;
  logic        req_now;
  logic [31:0] last_req_addr;

  c_fetch_buffer #(
    .DEPTH_HW (DEPTH_HW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sel_for_branch (sel_for_branch),
    .branch_pc_i    (branch_pc_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .pc_o           (pc_o),
    .is_comp_o      (is_comp_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] ramp_word(input int k);
    return 32'h0000_0013 | (32'(k) << 20);
  endfunction

  function automatic rec_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic comp);
    rec_t r;
    r.inst = inst; r.pc = pc; r.comp = comp; r.cyc = 0;
    return r;
  endfunction

  // One clock: sample at negedge, then drive memory response just after posedge.
  task automatic step();
    rec_t r;
    @(negedge clk);
    cyc++;
    req_now = mem_req_o;
    if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (inst_valid_o && inst_ready_i && !sel_for_branch) begin
      r.inst = inst_o; r.pc = pc_o; r.comp = is_comp_o; r.cyc = cyc;
      obs_q.push_back(r);
    end
    if (mem_req_o) begin
      req_addr_q.push_back(mem_addr_o);
      req_cyc_q.push_back(cyc);
      last_req_addr = mem_addr_o;
      pend_valid = 1'b1;
      pend_addr  = mem_addr_o;
      pend_wait  = resp_lat;
    end
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0000_0000;
    if (pend_valid) begin
      pend_wait--;
      if (pend_wait == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend_addr);
        pend_valid   = 1'b0;
      end
    end
  endtask

  task automatic apply_reset(input int lat, input logic ready);
    reset          = 1'b0;
    sel_for_branch = 1'b0;
    branch_pc_i    = 32'h0000_0000;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = 32'h0000_0000;
    inst_ready_i   = ready;
    pend_valid     = 1'b0;
    resp_lat       = lat;
    mem_words.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete(); obs_q.delete(); req_addr_q.delete(); req_cyc_q.delete();
    cyc = 0;
    first_valid_cyc = -1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst_o); end
    checks++; if (is_comp_o !== 1'b0) begin errors++; $display("FAIL reset_comp: got %b want 0", is_comp_o); end
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, RESET_PC); end
    checks++; if (mem_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", mem_addr_o, RESET_PC); end
  endtask

  task automatic test_mixed_sequence();
    rec_t e, o;
    apply_reset(1, 1'b1);
    mem_words[32'h0] = 32'h0001_4501;
    mem_words[32'h4] = 32'h0051_0113;
    exp_q.push_back(mk(32'h0000_4501, 32'h0, 1'b1));
    exp_q.push_back(mk(32'h0000_0001, 32'h2, 1'b1));
    exp_q.push_back(mk(32'h0051_0113, 32'h4, 1'b0));
    for (int i = 0; i < 40 && obs_q.size() < 3; i++) step();
    checks++;
    if (req_cyc_q.size() == 0 || first_valid_cyc - req_cyc_q[0] != 2) begin
      errors++; $display("FAIL first_latency: got valid cyc %0d, want first req cyc + 2", first_valid_cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL mixed timeout: missing inst pc=%h", e.pc); end
      else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          errors++; $display("FAIL mixed inst: got %h pc %h comp %b, want %h pc %h comp %b", o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
      end
    end
  endtask

  task automatic test_spanning();
    rec_t e, o;
    int prev_cyc;
    apply_reset(1, 1'b1);
    mem_words[32'h0] = 32'h0113_4501;
    mem_words[32'h4] = 32'h4505_0051;
    exp_q.push_back(mk(32'h0000_4501, 32'h0, 1'b1));
    exp_q.push_back(mk(32'h0051_0113, 32'h2, 1'b0));
    exp_q.push_back(mk(32'h0000_4505, 32'h6, 1'b1));
    for (int i = 0; i < 40 && obs_q.size() < 3; i++) step();
    prev_cyc = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL span timeout: missing inst pc=%h", e.pc); end
      else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          errors++; $display("FAIL span inst: got %h pc %h comp %b, want %h pc %h comp %b", o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
        if (prev_cyc >= 0) begin
          checks++;
          if (o.cyc != prev_cyc + 1) begin errors++; $display("FAIL span bubble: got cycle %0d want %0d", o.cyc, prev_cyc + 1); end
        end
        prev_cyc = o.cyc;
      end
    end
  endtask

  task automatic test_backpressure();
    rec_t e, o;
    logic changed;
    apply_reset(1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      mem_words[32'(k * 4)] = ramp_word(k);
      exp_q.push_back(mk(ramp_word(k), 32'(k * 4), 1'b0));
    end
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inst_valid_o && (inst_o !== ramp_word(0) || pc_o !== 32'h0)) changed = 1'b1;
    end
    checks++; if (req_addr_q.size() != 4) begin errors++; $display("FAIL full_reqs: got %0d requests want 4", req_addr_q.size()); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL full_req_low: got %b want 0", mem_req_o); end
    checks++; if (changed || inst_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold: changed=%b valid=%b want 0/1", changed, inst_valid_o); end
    inst_ready_i = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < 16; i++) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stall timeout: missing inst pc=%h", e.pc); end
      else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          errors++; $display("FAIL stall inst: got %h pc %h comp %b, want %h pc %h comp %b", o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
      end
    end
  endtask

  task automatic test_branch_kill();
    rec_t e, o;
    apply_reset(3, 1'b1);
    for (int k = 0; k < 16; k++) mem_words[32'(k * 4)] = ramp_word(k);
    mem_words[32'h40]  = 32'h1234_5677;
    mem_words[32'h100] = 32'h4505_1111;
    mem_words[32'h104] = 32'h0051_0113;
    for (int i = 0; i < 200; i++) begin
      step();
      if (req_now && last_req_addr == 32'h40) break;
    end
    checks++; if (last_req_addr !== 32'h40) begin errors++; $display("FAIL kill_setup: last req %h want 00000040", last_req_addr); end
    exp_q.push_back(mk(32'h0000_4505, 32'h102, 1'b1));
    exp_q.push_back(mk(32'h0051_0113, 32'h104, 1'b0));
    sel_for_branch = 1'b1;
    branch_pc_i    = 32'h0000_0102;
    obs_q.delete(); req_addr_q.delete();
    step();
    sel_for_branch = 1'b0;
    checks++; if (pc_o !== 32'h102) begin errors++; $display("FAIL kill_pc: got %h want 00000102", pc_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL kill_flush: valid %b want 0", inst_valid_o); end
    for (int i = 0; i < 60 && obs_q.size() < 2; i++) step();
    checks++;
    if (req_addr_q.size() == 0 || req_addr_q[0] !== 32'h100) begin
      errors++; $display("FAIL kill_addr: first req after redirect %h want 00000100", (req_addr_q.size() > 0) ? req_addr_q[0] : 32'hFFFF_FFFF);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL kill timeout: missing inst pc=%h", e.pc); end
      else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          errors++; $display("FAIL kill inst: got %h pc %h comp %b, want %h pc %h comp %b", o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
      end
    end
  endtask

  task automatic test_branch_collide();
    rec_t e, o;
    apply_reset(1, 1'b1);
    for (int k = 0; k < 32; k++) mem_words[32'(k * 4)] = ramp_word(k);
    mem_words[32'h200] = 32'h7770_0093;
    mem_words[32'h204] = 32'h4509_4505;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mem_rvalid_i && inst_valid_o && cyc > 6) break;
    end
    checks++; if (!(mem_rvalid_i && inst_valid_o)) begin errors++; $display("FAIL collide_setup: rvalid %b valid %b want 1/1", mem_rvalid_i, inst_valid_o); end
    exp_q.push_back(mk(32'h7770_0093, 32'h200, 1'b0));
    exp_q.push_back(mk(32'h0000_4505, 32'h204, 1'b1));
    exp_q.push_back(mk(32'h0000_4509, 32'h206, 1'b1));
    sel_for_branch = 1'b1;
    branch_pc_i    = 32'h0000_0201;
    obs_q.delete(); req_addr_q.delete();
    step();
    sel_for_branch = 1'b0;
    checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL collide_pc: got %h want 00000200", pc_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL collide_nopush: valid %b want 0", inst_valid_o); end
    for (int i = 0; i < 60 && obs_q.size() < 3; i++) step();
    checks++;
    if (req_addr_q.size() == 0 || req_addr_q[0] !== 32'h200) begin
      errors++; $display("FAIL collide_addr: first req after redirect %h want 00000200", (req_addr_q.size() > 0) ? req_addr_q[0] : 32'hFFFF_FFFF);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL collide timeout: missing inst pc=%h", e.pc); end
      else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          errors++; $display("FAIL collide inst: got %h pc %h comp %b, want %h pc %h comp %b", o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    rec_t e, o;
    apply_reset(3, 1'b1);
    for (int k = 0; k < 16; k++) mem_words[32'(k * 4)] = ramp_word(k);
    for (int i = 0; i < 200; i++) begin
      step();
      if (req_now && last_req_addr == 32'h10) break;
    end
    checks++; if (pc_o === RESET_PC) begin errors++; $display("FAIL midrst_setup: pc %h did not advance", pc_o); end
    reset        = 1'b0;
    mem_rvalid_i = 1'b0;
    pend_valid   = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", mem_req_o); end
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || is_comp_o !== 1'b0) begin
      errors++; $display("FAIL midrst_inst: valid %b inst %h comp %b want 0", inst_valid_o, inst_o, is_comp_o);
    end
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL midrst_pc: got %h want %h", pc_o, RESET_PC); end
    checks++; if (mem_addr_o !== RESET_PC) begin errors++; $display("FAIL midrst_addr: got %h want %h", mem_addr_o, RESET_PC); end
    @(posedge clk);
    #1 reset = 1'b1;
    obs_q.delete(); req_addr_q.delete(); req_cyc_q.delete();
    exp_q.push_back(mk(ramp_word(0), RESET_PC, 1'b0));
    exp_q.push_back(mk(ramp_word(1), RESET_PC + 32'd4, 1'b0));
    for (int i = 0; i < 60 && obs_q.size() < 2; i++) step();
    checks++;
    if (req_addr_q.size() == 0 || req_addr_q[0] !== RESET_PC) begin
      errors++; $display("FAIL midrst_restart: first req %h want %h", (req_addr_q.size() > 0) ? req_addr_q[0] : 32'hFFFF_FFFF, RESET_PC);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midrst timeout: missing inst pc=%h", e.pc); end
      else begin
        o = obs_q.pop_front();
        if (o.inst !== e.inst || o.pc !== e.pc || o.comp !== e.comp) begin
          errors++; $display("FAIL midrst inst: got %h pc %h comp %b, want %h pc %h comp %b", o.inst, o.pc, o.comp, e.inst, e.pc, e.comp);
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    sel_for_branch = 1'b0;
    branch_pc_i    = 32'h0000_0000;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = 32'h0000_0000;
    inst_ready_i   = 1'b0;
    pend_valid     = 1'b0;
    pend_wait      = 0;
    pend_addr      = 32'h0;
    resp_lat       = 1;
    req_now        = 1'b0;
    last_req_addr  = 32'h0;
    cyc            = 0;
    first_valid_cyc = -1;
    test_reset();
    test_mixed_sequence();
    test_spanning();
    test_backpressure();
    test_branch_kill();
    test_branch_collide();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
